pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
// Game-sequencing FSM for the pong datapath. Driven by the debounced start
// button, a one-per-frame tick and ball-miss pulses from the ball/paddle logic.
// Decides when the ball is held, frozen or running, and which way it is served.
// Keeps both scores, detects the winner and handles pause.
// Sits between the debouncers and the pixel driver in the P_CLK domain.
// PARAMETERS
// WIN_SCORE     7   points needed to win; scores saturate here
// SCORE_W       4   score counter width; must satisfy 2**SCORE_W > WIN_SCORE
// SERVE_FRAMES  60  frame_tick count spent in SERVE before the ball is released
// POINT_FRAMES  90  frame_tick count spent frozen in POINT after a miss
// PORTS
// P_CLK       in   1        pixel clock, all logic rising-edge
// RST         in   1        asynchronous, active-high reset
// start       in   1        debounced start/pause button level
// frame_tick  in   1        1-cycle pulse, once per video frame
// miss_left   in   1        1-cycle pulse: ball passed P1 (left) paddle
// miss_right  in   1        1-cycle pulse: ball passed P2 (right) paddle
// ball_run    out  1        ball motion enable
// ball_reset  out  1        hold ball at screen centre
// serve_dir   out  1        0 = serve toward P1 (left), 1 = toward P2 (right)
// score_p1    out  SCORE_W  P1 score
// score_p2    out  SCORE_W  P2 score
// game_over   out  1        high in GAME_OVER
// winner      out  1        0 = P1, 1 = P2; valid while game_over
// state       out  3        IDLE=0 SERVE=1 PLAY=2 PAUSE=3 POINT=4 OVER=5
// BEHAVIOUR
// - RST clears everything immediately:
//     state=IDLE, scores=0, serve_dir=0, winner=0, frame counter=0.
//     start_q=1, so a button held through reset causes no start.
// - Start edge: st_edge = start & ~start_q; start_q is registered every cycle.
// - Outputs are a Moore decode of the state register, so they move on the same
//   edge as the state:
//     ball_run=1 only in PLAY.
//     ball_reset=1 in IDLE and SERVE.
//     game_over=1 only in OVER.
// - IDLE, OVER: on st_edge -> SERVE; clear both scores and winner;
//   set serve_dir=0; load cnt=SERVE_FRAMES-1.
// - SERVE: on frame_tick, if cnt==0 -> PLAY, else cnt--. The ball is held for
//   exactly SERVE_FRAMES ticks. st_edge and misses are ignored.
// - PLAY:
//     miss_right only: P1 scores (score_p1+1); serve_dir=1.
//     miss_left only:  P2 scores (score_p2+1); serve_dir=0.
//     (The loser of the point is served toward.)
//     Both misses in the same cycle: no score, serve_dir unchanged.
//     After any miss: if the new score == WIN_SCORE -> OVER and winner=scorer;
//     else -> POINT with cnt=POINT_FRAMES-1.
//     A miss takes priority over st_edge and frame_tick in the same cycle.
//     st_edge with no miss -> PAUSE.
// - PAUSE: st_edge -> PLAY; misses and frame_tick are ignored; cnt is held.
// - POINT: the ball is frozen (ball_run=0, ball_reset=0). On frame_tick, if
//   cnt==0 -> SERVE with cnt=SERVE_FRAMES-1, else cnt--. st_edge is ignored.
// - Score arithmetic: unsigned; never exceeds WIN_SCORE; never wraps.
// - Frame counter: width is $clog2(max(SERVE_FRAMES,POINT_FRAMES)).
//   A parameter value of 1 means one tick.
// - Unused state encodings (6, 7) -> IDLE on the next clock.
// - RST asserted mid-game: asynchronous return to the reset values; there is
//   no partial state.
// TESTING
// - Reset with start held high, release RST -> state stays IDLE
//   (0), ball_reset=1, ball_run=0.
// - Start pulse in IDLE -> state=1 next cycle, scores=0. After 60 frame_ticks
//   -> state=2 and ball_run=1 on that edge, not before tick 60.
// - In PLAY, miss_right -> score_p1=1, serve_dir=1, state=4. After 90 ticks
//   -> state=1.
// - score_p2=6, then miss_left in PLAY -> score_p2=7, state=5, game_over=1,
//   winner=1. Further misses ignored. Start pulse -> state=1, scores=0,
//   winner=0.
// - miss_left and miss_right in the same cycle -> scores unchanged, state=4.
//   Start pulse in PLAY -> state=3 (PAUSE); a miss in PAUSE is ignored;
//   start again -> state=2.
// - RST asserted mid-POINT with cnt=40 -> all outputs at reset values
//   immediately, with no P_CLK edge needed.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Game-sequencing controller for the pong datapath: serve/play/pause/point
// sequencing, score keeping with saturation at WIN_SCORE, and winner detection.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               P_CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic               dir_q, dir_d;
  logic               win_q, win_d;
  logic               start_q;
  logic               st_edge;

  assign st_edge = start & ~start_q;
  assign p1_inc  = (p1_q >= SCORE_MAX) ? SCORE_MAX : p1_q + SCORE_W'(1);
  assign p2_inc  = (p2_q >= SCORE_MAX) ? SCORE_MAX : p2_q + SCORE_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge P_CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
      start_q <= 1'b1;  // a button held through reset must not start a game
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      start_q <= start;
    end
  end

  // NOTE: every output of this block is given a hold value first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    dir_d   = dir_q;
    win_d   = win_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (st_edge) begin
          state_d = S_SERVE;
          cnt_d   = SERVE_LOAD;
          p1_d    = '0;
          p2_d    = '0;
          dir_d   = 1'b0;
          win_d   = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_PLAY: begin
        // Misses outrank pause and frame ticks; the loser is served toward.
        if (miss_left && miss_right) begin
          state_d = S_POINT;
          cnt_d   = POINT_LOAD;
        end else if (miss_right) begin
          p1_d  = p1_inc;
          dir_d = 1'b1;
          if (p1_inc == SCORE_MAX) begin
            state_d = S_OVER;
            win_d   = 1'b0;
          end else begin
            state_d = S_POINT;
            cnt_d   = POINT_LOAD;
          end
        end else if (miss_left) begin
          p2_d  = p2_inc;
          dir_d = 1'b0;
          if (p2_inc == SCORE_MAX) begin
            state_d = S_OVER;
            win_d   = 1'b1;
          end else begin
            state_d = S_POINT;
            cnt_d   = POINT_LOAD;
          end
        end else if (st_edge) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (st_edge) state_d = S_PLAY;
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            state_d = S_SERVE;
            cnt_d   = SERVE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ball_run   = (state_q == S_PLAY);
  assign ball_reset = (state_q == S_IDLE) || (state_q == S_SERVE);
  assign game_over  = (state_q == S_OVER);
  assign serve_dir  = dir_q;
  assign winner     = win_q;
  assign score_p1   = p1_q;
  assign score_p2   = p2_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a rule-level reference model.
module tb_pong_game_ctrl;

  localparam int WIN = 7;
  localparam int SF  = 60;
  localparam int PF  = 90;

  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_PAUSE = 3, ST_POINT = 4, ST_OVER = 5;

  logic       P_CLK = 1'b0;
  logic       RST;
  logic       start, frame_tick, miss_left, miss_right;
  logic       ball_run, ball_reset, serve_dir, game_over, winner;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state;

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SCORE_W(4), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .P_CLK(P_CLK), .RST(RST), .start(start), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .ball_run(ball_run),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score_p1(score_p1),
    .score_p2(score_p2), .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 P_CLK = ~P_CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game phase, scores and frames remaining, as plain integers.
  int m_state, m_p1, m_p2, m_dir, m_win, m_frames, m_prev_start;

  task automatic m_reset();
    m_state = ST_IDLE; m_p1 = 0; m_p2 = 0; m_dir = 0; m_win = 0;
    m_frames = 0; m_prev_start = 1;
  endtask

  task automatic m_score(input int who);
    if (who == 1) begin
      m_p1 = (m_p1 < WIN) ? m_p1 + 1 : WIN;
      m_dir = 1;
      if (m_p1 == WIN) begin m_state = ST_OVER; m_win = 0; end
      else begin m_state = ST_POINT; m_frames = PF; end
    end else begin
      m_p2 = (m_p2 < WIN) ? m_p2 + 1 : WIN;
      m_dir = 0;
      if (m_p2 == WIN) begin m_state = ST_OVER; m_win = 1; end
      else begin m_state = ST_POINT; m_frames = PF; end
    end
  endtask

  task automatic m_step(input bit s, input bit ft, input bit ml, input bit mr);
    bit pressed;
    pressed = s && (m_prev_start == 0);
    if (m_state == ST_IDLE || m_state == ST_OVER) begin
      if (pressed) begin
        m_state = ST_SERVE; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_frames = SF;
      end
    end else if (m_state == ST_SERVE) begin
      // m_frames counts ticks still to wait; the last one releases the ball
      if (ft) begin
        m_frames = m_frames - 1;
        if (m_frames == 0) m_state = ST_PLAY;
      end
    end else if (m_state == ST_PLAY) begin
      if (ml && mr) begin m_state = ST_POINT; m_frames = PF; end
      else if (mr) m_score(1);
      else if (ml) m_score(2);
      else if (pressed) m_state = ST_PAUSE;
    end else if (m_state == ST_PAUSE) begin
      if (pressed) m_state = ST_PLAY;
    end else if (m_state == ST_POINT) begin
      if (ft) begin
        m_frames = m_frames - 1;
        if (m_frames == 0) begin m_state = ST_SERVE; m_frames = SF; end
      end
    end
    m_prev_start = s;
  endtask

  function automatic logic [31:0] model_word();
    logic [2:0] st3;
    logic [3:0] a, b;
    st3 = 3'(m_state); a = 4'(m_p1); b = 4'(m_p2);
    return {16'd0, st3, m_state == ST_PLAY, m_state <= ST_SERVE, m_dir[0],
            a, b, m_state == ST_OVER, m_win[0]};
  endfunction

  function automatic logic [31:0] dut_word();
    return {16'd0, state, ball_run, ball_reset, serve_dir, score_p1, score_p2,
            game_over, winner};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Inputs change #1 after an edge; outputs are compared #1 after the next edge.
  task automatic do_cycle(input bit s, input bit ft, input bit ml, input bit mr);
    start = s; frame_tick = ft; miss_left = ml; miss_right = mr;
    @(posedge P_CLK);
    m_step(s, ft, ml, mr);
    #1;
    check("cycle", dut_word(), model_word());
  endtask

  task automatic go_play();
    for (int i = 0; i < 400 && m_state != ST_PLAY; i++) do_cycle(0, 1, 0, 0);
    check("reach_play", 32'(state), 32'(ST_PLAY));
  endtask

  typedef struct {
    bit st, ft, ml, mr;
    int reps;
    int e_state, e_p1, e_p2, e_dir;
  } vec_t;

  vec_t tbl[22];

  initial begin
    tbl[0]  = '{1, 0, 0, 0,  3, ST_IDLE,  0, 0, 0};  // start held through reset
    tbl[1]  = '{0, 0, 0, 0,  1, ST_IDLE,  0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0,  1, ST_SERVE, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 59, ST_SERVE, 0, 0, 0};  // not yet released
    tbl[4]  = '{0, 1, 0, 0,  1, ST_PLAY,  0, 0, 0};  // tick 60
    tbl[5]  = '{0, 0, 0, 1,  1, ST_POINT, 1, 0, 1};
    tbl[6]  = '{0, 1, 0, 0, 89, ST_POINT, 1, 0, 1};
    tbl[7]  = '{0, 1, 0, 0,  1, ST_SERVE, 1, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 60, ST_PLAY,  1, 0, 1};
    tbl[9]  = '{0, 0, 1, 1,  1, ST_POINT, 1, 0, 1};  // double miss
    tbl[10] = '{0, 1, 0, 0, 90, ST_SERVE, 1, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 60, ST_PLAY,  1, 0, 1};
    tbl[12] = '{1, 0, 0, 0,  1, ST_PAUSE, 1, 0, 1};
    tbl[13] = '{0, 0, 1, 0,  1, ST_PAUSE, 1, 0, 1};  // miss ignored in pause
    tbl[14] = '{0, 1, 0, 0,  5, ST_PAUSE, 1, 0, 1};
    tbl[15] = '{1, 0, 0, 0,  1, ST_PLAY,  1, 0, 1};
    tbl[16] = '{0, 1, 1, 0,  1, ST_POINT, 1, 1, 0};  // miss beats tick
    tbl[17] = '{0, 1, 0, 0, 90, ST_SERVE, 1, 1, 0};
    tbl[18] = '{0, 1, 0, 0, 60, ST_PLAY,  1, 1, 0};
    tbl[19] = '{1, 0, 0, 1,  1, ST_POINT, 2, 1, 1};  // miss beats start edge
    tbl[20] = '{1, 1, 0, 0, 90, ST_SERVE, 2, 1, 1};
    tbl[21] = '{0, 0, 0, 0,  1, ST_SERVE, 2, 1, 1};

    RST = 1'b1; start = 1'b1; frame_tick = 0; miss_left = 0; miss_right = 0;
    m_reset();
    repeat (3) @(posedge P_CLK);
    #1;
    RST = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_ball_reset", 32'(ball_reset), 32'd1);
    check("rst_ball_run", 32'(ball_run), 32'd0);
    @(posedge P_CLK);
    #1;
    check("rst_hold", dut_word(), model_word());

    foreach (tbl[i]) begin
      repeat (tbl[i].reps) do_cycle(tbl[i].st, tbl[i].ft, tbl[i].ml, tbl[i].mr);
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
      check($sformatf("tbl%0d_p1", i), 32'(score_p1), 32'(tbl[i].e_p1));
      check($sformatf("tbl%0d_p2", i), 32'(score_p2), 32'(tbl[i].e_p2));
      check($sformatf("tbl%0d_dir", i), 32'(serve_dir), 32'(tbl[i].e_dir));
    end

    // P2 runs up to six points, then takes the winning one.
    for (int k = 0; k < 10 && m_p2 < WIN - 1; k++) begin
      go_play();
      do_cycle(0, 0, 1, 0);
    end
    go_play();
    check("pre_win_p2", 32'(score_p2), 32'd6);
    do_cycle(0, 0, 1, 0);
    check("win_state", 32'(state), 32'(ST_OVER));
    check("win_p2", 32'(score_p2), 32'd7);
    check("win_over", 32'(game_over), 32'd1);
    check("win_winner", 32'(winner), 32'd1);
    do_cycle(0, 1, 1, 1);
    check("over_p1", 32'(score_p1), 32'd2);
    check("over_p2", 32'(score_p2), 32'd7);
    check("over_state", 32'(state), 32'(ST_OVER));
    do_cycle(1, 0, 0, 0);
    check("restart_state", 32'(state), 32'(ST_SERVE));
    check("restart_scores", 32'({score_p1, score_p2}), 32'd0);
    check("restart_winner", 32'(winner), 32'd0);
    do_cycle(0, 0, 0, 0);

    // Reset in the middle of POINT with 40 frames still counted.
    go_play();
    do_cycle(0, 0, 0, 1);
    repeat (49) do_cycle(0, 1, 0, 0);
    check("pre_rst_state", 32'(state), 32'(ST_POINT));
    #2;
    RST = 1'b1;
    #1;
    check("async_rst", dut_word(), {16'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    m_reset();
    @(posedge P_CLK);
    #1;
    RST = 1'b0;

    // Randomized play against the model.
    begin
      bit s = 0;
      for (int i = 0; i < 20000; i++) begin
        if ($urandom_range(39) == 0) s = ~s;
        do_cycle(s, $urandom_range(1), $urandom_range(15) == 0, $urandom_range(15) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
